// File: rtl/mapper_mask_ref.sv
// Purpose: M-ASK in-phase mapper with a run-time reference level and shadow/active level tables.
// Latency: 1 core clock from a clk_en edge to sym_out; table rebuild takes M/2 clocks plus a swap on the next clk_en edge.
// Backpressure: none; one symbol is taken on every clk_en cycle, and ref_busy only reports a pending rebuild.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   clk_en, data        symbol-rate enable and symbol bits (BPS wide)
//   ref_level, ref_load signed reference and single-cycle rebuild request
//   sym_out             registered mapped level (signed, WIDTH wide)
//   ref_busy            rebuild or swap pending
//   tbl_valid           active table loaded at least once since reset
//   lvl_idx, lvl_out    combinational read of the active table in amplitude order
//
// Build option: define MAPPER_GRAY_EN for Gray-coded symbol mapping; the default
// is offset binary, bit-compatible with the legacy 4-ASK mapper.
module mapper_mask_ref #(
    parameter int WIDTH = 18,
    parameter int BPS   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clk_en,
    input  logic [BPS-1:0]          data,
    input  logic signed [WIDTH-1:0] ref_level,
    input  logic                    ref_load,
    output logic signed [WIDTH-1:0] sym_out,
    output logic                    ref_busy,
    output logic                    tbl_valid,
    input  logic [BPS-1:0]          lvl_idx,
    output logic signed [WIDTH-1:0] lvl_out
);
    localparam int M  = 1 << BPS;
    localparam int AW = WIDTH + BPS + 1;
    localparam logic [BPS-1:0] HALF = BPS'(M / 2);
    localparam logic [BPS-1:0] LAST = BPS'(M / 2 - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SWAP} state_t;

    state_t                  state, state_nxt;
    logic                    capture, wr_en, swap;
    logic signed [WIDTH-1:0] shadow [M];
    logic signed [WIDTH-1:0] active [M];
    logic signed [AW-1:0]    p_acc, n_acc, step;
    logic [BPS-1:0]          idx;
    logic [BPS-1:0]          sym_k;
    logic signed [AW-1:0]    ref_ext, h_ext;

    assign ref_ext = AW'(ref_level);
    assign h_ext   = ref_ext >>> 1;

    // Clamp an accumulator to the signed WIDTH range: overflow shows up as
    // the bits above the WIDTH-1 sign bit disagreeing with the top bit.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
        if (v[AW-1] && !(&v[AW-2:WIDTH-1]))
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        else if (!v[AW-1] && (|v[AW-2:WIDTH-1]))
            sat = {1'b0, {(WIDTH-1){1'b1}}};
        else
            sat = v[WIDTH-1:0];
    endfunction

`ifdef MAPPER_GRAY_EN
    // data is the Gray code of u = k ^ (M/2); decode Gray to binary, then undo the offset.
    logic [BPS-1:0] gray_bin;
    always_comb begin
        gray_bin = '0;
        gray_bin[BPS-1] = data[BPS-1];
        for (int b = BPS - 2; b >= 0; b--)
            gray_bin[b] = gray_bin[b+1] ^ data[b];
    end
    assign sym_k = gray_bin ^ HALF;
`else
    // Offset binary: flipping the MSB turns the symbol into amplitude order.
    assign sym_k = data ^ HALF;
`endif

    // Next-state logic. A new ref_load always wins: it restarts the build from
    // the new reference, even on a cycle that would otherwise write or swap.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        wr_en     = 1'b0;
        swap      = 1'b0;
        case (state)
            IDLE: begin
                if (ref_load) begin
                    capture   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (ref_load) begin
                    capture = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    if (idx == LAST)
                        state_nxt = SWAP;
                end
            end
            SWAP: begin
                if (ref_load) begin
                    capture   = 1'b1;
                    state_nxt = LOAD;
                end else if (clk_en) begin
                    swap      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Table build fills outward from the centre: P walks up the positive
    // half, N walks down the negative half, one pair of entries per clock.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p_acc     <= '0;
            n_acc     <= '0;
            step      <= '0;
            idx       <= '0;
            tbl_valid <= 1'b0;
            sym_out   <= '0;
            for (int j = 0; j < M; j++) begin
                shadow[j] <= '0;
                active[j] <= '0;
            end
        end else begin
            if (capture) begin
                p_acc <= h_ext;
                n_acc <= -h_ext;
                step  <= ref_ext;
                idx   <= '0;
            end else if (wr_en) begin
                shadow[HALF + idx] <= sat(p_acc);
                shadow[LAST - idx] <= sat(n_acc);
                p_acc <= p_acc + step;
                n_acc <= n_acc - step;
                idx   <= idx + 1'b1;
            end
            if (swap) begin
                active    <= shadow;
                tbl_valid <= 1'b1;
            end
            // Reads the pre-swap active table on the swap edge by construction.
            if (clk_en)
                sym_out <= active[sym_k];
        end
    end

    assign ref_busy = (state != IDLE);
    assign lvl_out  = active[lvl_idx];

endmodule

// File: tb/tb_mapper_mask_ref.sv
module tb_mapper_mask_ref;
    logic               clk;
    logic               reset_n;
    logic               clk_en;
    logic [1:0]         data;
    logic signed [17:0] ref_level;
    logic               ref_load;
    logic signed [17:0] sym_out;
    logic               ref_busy;
    logic               tbl_valid;
    logic [1:0]         lvl_idx;
    logic signed [17:0] lvl_out;

    logic [2:0]         data3;
    logic signed [17:0] ref3;
    logic               ref_load3;
    logic signed [17:0] sym3;
    logic               busy3;
    logic               valid3;
    logic [2:0]         lvl_idx3;
    logic signed [17:0] lvl3;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    mapper_mask_ref #(.WIDTH(18), .BPS(2)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .data(data),
        .ref_level(ref_level), .ref_load(ref_load), .sym_out(sym_out),
        .ref_busy(ref_busy), .tbl_valid(tbl_valid), .lvl_idx(lvl_idx),
        .lvl_out(lvl_out)
    );

    mapper_mask_ref #(.WIDTH(18), .BPS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .data(data3),
        .ref_level(ref3), .ref_load(ref_load3), .sym_out(sym3),
        .ref_busy(busy3), .tbl_valid(valid3), .lvl_idx(lvl_idx3),
        .lvl_out(lvl3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (4-ASK instance) ----------------
    int m_active [4];
    int m_ref;
    int m_wait;
    bit m_busy;
    bit m_valid;
    int m_sym;

    function automatic int sat18(input int v);
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    // level[k] = (2k - (M-1)) * (ref >>> 1), saturated
    function automatic int level4(input int r, input int k);
        int h;
        h = r >>> 1;
        return sat18((2 * k - 3) * h);
    endfunction

    function automatic int map_k(input int d);
        int u;
`ifdef MAPPER_GRAY_EN
        u = d ^ (d >> 1);
`else
        u = d;
`endif
        return u ^ 2;
    endfunction

    always @(posedge clk) begin
        int new_sym;
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) m_active[k] = 0;
            m_busy = 0; m_valid = 0; m_sym = 0; m_wait = 0; m_ref = 0;
        end else begin
            new_sym = m_active[map_k(int'(data))];
            if (ref_load) begin
                m_ref  = int'(ref_level);
                m_busy = 1;
                m_wait = 2;
            end else if (m_busy) begin
                if (m_wait > 0) begin
                    m_wait--;
                end else if (clk_en) begin
                    for (int k = 0; k < 4; k++) m_active[k] = level4(m_ref, k);
                    m_valid = 1;
                    m_busy  = 0;
                end
            end
            if (clk_en) m_sym = new_sym;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("sym_out", sym_out, m_sym);
            check("ref_busy", {31'b0, ref_busy}, {31'b0, m_busy});
            check("tbl_valid", {31'b0, tbl_valid}, {31'b0, m_valid});
            check("lvl_out", lvl_out, m_active[lvl_idx]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic bit is_old(input int v);
        return (v == 500) || (v == -500) || (v == 1500) || (v == -1500);
    endfunction

    int dl [4] = '{0, 1, 3, 2};
`ifdef MAPPER_GRAY_EN
    int el [4] = '{500, 1500, -1500, -500};
`else
    int el [4] = '{500, 1500, -500, -1500};
`endif
    int lv4 [4] = '{-1500, -500, 500, 1500};
    int lv8 [8] = '{-131072, -131072, -131072, -50000, 50000, 131071, 131071, 131071};
    int lv4b [4] = '{-600, -200, 200, 600};

    initial begin
        int busy_cnt;
        int swap_seen;
        bit bad;
        bit prev_busy;
        bit en_applied;
        logic [31:0] r;

        reset_n = 0; clk_en = 0; data = 0; ref_level = 0; ref_load = 0; lvl_idx = 0;
        data3 = 0; ref3 = 0; ref_load3 = 0; lvl_idx3 = 0;
        cyc(); cyc();
        chk_en = 1;
        check("reset_sym", sym_out, 0);
        check("reset_busy", {31'b0, ref_busy}, 0);
        check("reset_valid", {31'b0, tbl_valid}, 0);
        reset_n = 1;

        // No table loaded: everything maps to zero.
        clk_en = 1;
        for (int i = 0; i < 8; i++) begin
            data = 2'(i);
            cyc();
            check("unloaded_sym", sym_out, 0);
        end
        check("unloaded_valid", {31'b0, tbl_valid}, 0);
        check("unloaded_busy", {31'b0, ref_busy}, 0);

        // Load ref=1000 with clk_en high.
        ref_level = 18'sd1000; ref_load = 1;
        cyc();
        ref_load = 0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (ref_busy) busy_cnt++;
            cyc();
        end
        check("busy_cycles", busy_cnt, 3);
        check("valid_after_load", {31'b0, tbl_valid}, 1);
        for (int i = 0; i < 4; i++) begin
            data = 2'(dl[i]);
            cyc();
            check("map_1000", sym_out, el[i]);
        end
        for (int k = 0; k < 4; k++) begin
            lvl_idx = 2'(k);
            #1;
            check("lvl_1000", lvl_out, lv4[k]);
        end

        // 8-ASK saturation table.
        ref3 = 18'sd100000; ref_load3 = 1;
        cyc();
        ref_load3 = 0;
        repeat (6) cyc();
        check("m8_valid", {31'b0, valid3}, 1);
        for (int k = 0; k < 8; k++) begin
            lvl_idx3 = 3'(k);
            #1;
            check("m8_lvl", lvl3, lv8[k]);
        end

        // Back-to-back reloads with sparse clk_en.
        bad = 0; swap_seen = 0; prev_busy = ref_busy;
        for (int n = 0; n < 40; n++) begin
            clk_en = (n % 4 == 0);
            data = 2'($urandom);
            ref_load = 0;
            if (n == 1) begin ref_level = 18'sd2000; ref_load = 1; end
            if (n == 2) begin ref_level = 18'sd400;  ref_load = 1; end
            en_applied = clk_en;
            cyc();
            if (sym_out == 1000 || sym_out == -1000 || sym_out == 3000 || sym_out == -3000) bad = 1;
            if (prev_busy && !ref_busy) begin
                swap_seen++;
                check("swap_on_clk_en", {31'b0, en_applied}, 1);
                check("swap_edge_old_level", {31'b0, is_old(int'(sym_out))}, 1);
            end
            prev_busy = ref_busy;
        end
        ref_load = 0;
        check("no_intermediate", {31'b0, bad}, 0);
        check("swap_count", swap_seen, 1);
        for (int k = 0; k < 4; k++) begin
            lvl_idx = 2'(k);
            #1;
            check("lvl_400", lvl_out, lv4b[k]);
        end

        // Reset in the middle of a rebuild.
        clk_en = 1; lvl_idx = 3;
        ref_level = 18'sd1000; ref_load = 1;
        cyc();
        ref_load = 0;
        cyc();
        reset_n = 0;
        cyc();
        check("rst_load_sym", sym_out, 0);
        check("rst_load_busy", {31'b0, ref_busy}, 0);
        check("rst_load_valid", {31'b0, tbl_valid}, 0);
        check("rst_load_lvl", lvl_out, 0);
        reset_n = 1;
        ref_load = 1;
        cyc();
        ref_load = 0;
        repeat (4) cyc();
        check("reload_valid", {31'b0, tbl_valid}, 1);
        check("reload_lvl", lvl_out, 1500);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            clk_en   = 1'($urandom_range(0, 1));
            data     = 2'($urandom);
            lvl_idx  = 2'($urandom);
            ref_load = ($urandom_range(0, 15) == 0);
            r = $urandom;
            ref_level = {r[17:1], 1'b0};
            reset_n  = ($urandom_range(0, 299) != 0);
            cyc();
        end
        reset_n = 1; ref_load = 0;
        cyc();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
